lcd_backlight_ctrl: RTL

Consumes the `lcd_led_level[4:0]` and `pwr_off_req` fields produced by the GPIO splitter and drives the LCD backlight enable pin with a PWM waveform. Brightness changes fade linearly instead of stepping. On a power-off request the backlight fades to dark and raises a sticky completion flag for the power sequencer. It sits between the GPIO splitter and the top-level LCD backlight pad.

---
 rtl/lcd_bl_pkg.sv | 26 ++
 rtl/bl_pwm_gen.sv | 58 +++++
 rtl/lcd_backlight_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lcd_bl_pkg.sv
// ---------------------------------------------------------------------------
// lcd_bl_pkg
// Shared definitions for the LCD backlight controller:
//   DUTY_W        width of the PWM duty value and PWM counter
//   bl_state_e    fade state machine states
//   level_to_duty maps the 5-bit GPIO brightness level onto the 8-bit duty
//                 scale (0 -> 0, 31 -> 255, monotonic)
// ---------------------------------------------------------------------------
package lcd_bl_pkg;

   localparam int DUTY_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      OFF  = 2'd3
   } bl_state_e;

   // Replicating the top bits of the level into the low bits stretches the
   // 0..31 range onto 0..255, so full level reaches full duty.
   function automatic logic [DUTY_W-1:0] level_to_duty(input logic [4:0] level);
      return {level, level[4:2]};
   endfunction

endpackage

// File: rtl/bl_pwm_gen.sv
// ---------------------------------------------------------------------------
// bl_pwm_gen
// PWM generator for the backlight pin: prescaler, free-running 8-bit PWM
// counter and a registered duty compare.
// Ports:
//   clock_i  system clock
//   reset_i  asynchronous active-high reset
//   duty_i   duty value to compare against (0 = always low, 255 = 255/256)
//   pb_o     single-cycle period boundary (last tick of the PWM period)
//   pwm_o    registered PWM output, lags the compare by one clock
// ---------------------------------------------------------------------------
module bl_pwm_gen
   import lcd_bl_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [DUTY_W-1:0] duty_i,
   output logic              pb_o,
   output logic              pwm_o
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0]  preCnt_q, preCnt_d;
   logic [DUTY_W-1:0] pwmCnt_q, pwmCnt_d;
   logic              pwm_q, pwm_d;
   logic              tick;

   // The PWM counter only advances once every PRESCALE clocks; with
   // PRESCALE = 1 the prescaler is a constant zero and tick is always high.
   always_comb begin
      tick     = (preCnt_q == PRE_MAX);
      preCnt_d = tick ? '0 : preCnt_q + PRE_W'(1);
      pwmCnt_d = tick ? pwmCnt_q + DUTY_W'(1) : pwmCnt_q;
      pwm_d    = (pwmCnt_q < duty_i);
      pb_o     = tick && (pwmCnt_q == {DUTY_W{1'b1}});
   end

   // Counters and the output compare register. Registering the compare keeps
   // the pad free of combinational glitches from the counter.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         preCnt_q <= '0;
         pwmCnt_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         preCnt_q <= preCnt_d;
         pwmCnt_q <= pwmCnt_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/lcd_backlight_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_backlight_ctrl
// Drives the LCD backlight pad with PWM. Brightness changes fade one duty
// step every RAMP_PERIODS PWM periods; a power-off request fades to dark and
// then latches a sticky completion flag until reset.
// Ports:
//   aclk           system clock
//   areset         asynchronous active-high reset
//   lcd_led_level  requested brightness (0 = off, 31 = max)
//   pwr_off_req    while high the fade target is forced to 0
//   lcd_bl_pwm     registered PWM output to the pad
//   duty_cur       duty currently applied
//   ramp_busy      high while a fade is in progress
//   bl_off_done    sticky, set once dark under a power-off request
// ---------------------------------------------------------------------------
module lcd_backlight_ctrl
   import lcd_bl_pkg::*;
#(
   parameter int PRESCALE     = 4,
   parameter int RAMP_PERIODS = 2
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [4:0]        lcd_led_level,
   input  logic              pwr_off_req,
   output logic              lcd_bl_pwm,
   output logic [DUTY_W-1:0] duty_cur,
   output logic              ramp_busy,
   output logic              bl_off_done
);

   localparam int STEP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(RAMP_PERIODS - 1);

   bl_state_e         state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [STEP_W-1:0] stepCnt_q, stepCnt_d;
   logic              offDone_q, offDone_d;

   logic [DUTY_W-1:0] tgt;
   logic [DUTY_W-1:0] dutyInc;
   logic [DUTY_W-1:0] dutyDec;
   logic              stepDue;
   logic              pb;

   // The PWM generator reports the period boundary; all duty updates are
   // aligned to it so a PWM period never sees a mid-period duty change.
   bl_pwm_gen #(
      .PRESCALE (PRESCALE)
   ) uPwmGen (
      .clock_i (aclk),
      .reset_i (areset),
      .duty_i  (duty_q),
      .pb_o    (pb),
      .pwm_o   (lcd_bl_pwm)
   );

   // Fade target and the neighbouring duty values used by the stepper.
   always_comb begin
      tgt     = pwr_off_req ? '0 : level_to_duty(lcd_led_level);
      dutyInc = duty_q + DUTY_W'(1);
      dutyDec = duty_q - DUTY_W'(1);
      stepDue = (stepCnt_q == STEP_MAX);
   end

   // State, duty, step counter and done flag registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= IDLE;
         duty_q    <= '0;
         stepCnt_q <= '0;
         offDone_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         duty_q    <= duty_d;
         stepCnt_q <= stepCnt_d;
         offDone_q <= offDone_d;
      end
   end

   // Next-state logic, evaluated only on period boundaries. A direction
   // reversal restarts the step count without touching duty, so the duty
   // sequence never skips or repeats a value. OFF is absorbing.
   always_comb begin
      state_d   = state_q;
      duty_d    = duty_q;
      stepCnt_d = stepCnt_q;
      offDone_d = offDone_q;
      if (pb) begin
         case (state_q)
            IDLE: begin
               stepCnt_d = '0;
               if (pwr_off_req && (duty_q == '0)) begin
                  state_d   = OFF;
                  offDone_d = 1'b1;
               end else if (tgt > duty_q) begin
                  state_d = UP;
               end else if (tgt < duty_q) begin
                  state_d = DOWN;
               end
            end
            UP: begin
               if (tgt < duty_q) begin
                  state_d   = DOWN;
                  stepCnt_d = '0;
               end else if (tgt == duty_q) begin
                  state_d   = IDLE;
                  stepCnt_d = '0;
               end else if (stepDue) begin
                  duty_d    = dutyInc;
                  stepCnt_d = '0;
                  if (dutyInc == tgt) begin
                     state_d = IDLE;
                  end
               end else begin
                  stepCnt_d = stepCnt_q + STEP_W'(1);
               end
            end
            DOWN: begin
               if (tgt > duty_q) begin
                  state_d   = UP;
                  stepCnt_d = '0;
               end else if (tgt == duty_q) begin
                  state_d   = IDLE;
                  stepCnt_d = '0;
               end else if (stepDue) begin
                  duty_d    = dutyDec;
                  stepCnt_d = '0;
                  if (dutyDec == tgt) begin
                     state_d = IDLE;
                  end
               end else begin
                  stepCnt_d = stepCnt_q + STEP_W'(1);
               end
            end
            OFF: begin
               state_d = OFF;
            end
            default: begin
               state_d   = IDLE;
               stepCnt_d = '0;
            end
         endcase
      end
   end

   // Outputs are straight decodes of the registered state.
   always_comb begin
      duty_cur    = duty_q;
      ramp_busy   = (state_q == UP) || (state_q == DOWN);
      bl_off_done = offDone_q;
   end

endmodule
